// File: rtl/rtc_bus_cycle_if.sv
// Host-side request/response bundle for the RTC multiplexed-bus cycle engine.
interface rtc_bus_cycle_if;
  logic       req;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (output req, wr, addr, wdata, input busy, done, rdata);
  modport slave  (input req, wr, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/rtc_bus_cycle.sv
// Runs one address-then-data cycle on a multiplexed RTC bus (AD/CS/RD/WR strobes),
// with per-phase dwell timed by a single reloadable down-counter.
module rtc_bus_cycle #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_REC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  rtc_bus_cycle_if.slave   host,
  output logic             AD,
  output logic             CS,
  output logic             RD,
  output logic             WR,
  output logic [7:0]       bus_out,
  output logic             bus_oe,
  input  logic [7:0]       bus_in
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 8;

  // Counter reload values are dwell-1; a zero dwell is treated as one cycle.
  localparam logic [CW-1:0] LD_SETUP = CW'((T_SETUP == 0) ? 0 : T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'((T_PULSE == 0) ? 0 : T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'((T_HOLD  == 0) ? 0 : T_HOLD  - 1);
  localparam logic [CW-1:0] LD_REC   = CW'((T_REC   == 0) ? 0 : T_REC   - 1);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, REC
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_wr_q, cyc_wr_d;
  logic [DW-1:0]   cyc_addr_q, cyc_addr_d;
  logic [DW-1:0]   cyc_wdata_q, cyc_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ad_q, ad_d;
  logic            cs_q, cs_d;
  logic            rd_q, rd_d;
  logic            wrs_q, wrs_d;
  logic            bus_oe_q, bus_oe_d;
  logic [DW-1:0]   bus_out_q, bus_out_d;

  function automatic logic [CW-1:0] reload(input state_e s);
    case (s)
      A_SET, D_SET: return LD_SETUP;
      A_STB, D_STB: return LD_PULSE;
      A_HLD, D_HLD: return LD_HOLD;
      REC:          return LD_REC;
      default:      return '0;
    endcase
  endfunction

  function automatic state_e next_phase(input state_e s);
    case (s)
      A_SET:   return A_STB;
      A_STB:   return A_HLD;
      A_HLD:   return D_SET;
      D_SET:   return D_STB;
      D_STB:   return D_HLD;
      D_HLD:   return REC;
      default: return IDLE;
    endcase
  endfunction

  // Sequencing, then strobes derived from the next state so every pin is a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_wr_d    = cyc_wr_q;
    cyc_addr_d  = cyc_addr_q;
    cyc_wdata_d = cyc_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;

    if (state_q == IDLE) begin
      if (host.req) begin
        state_d     = A_SET;
        cyc_wr_d    = host.wr;
        cyc_addr_d  = host.addr;
        cyc_wdata_d = host.wdata;
      end
    end else if (cnt_q == '0) begin
      state_d = next_phase(state_q);
      if ((state_q == D_STB) && !cyc_wr_q) rdata_d = bus_in;
      if (state_q == REC) done_d = 1'b1;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end

    if (state_d != state_q) cnt_d = reload(state_d);

    busy_d    = (state_d != IDLE);
    ad_d      = (state_d != A_STB);
    cs_d      = (state_d == IDLE) || (state_d == REC);
    rd_d      = !((state_d == D_STB) && !cyc_wr_d);
    wrs_d     = !((state_d == D_STB) && cyc_wr_d);
    bus_oe_d  = 1'b0;
    bus_out_d = bus_out_q;
    case (state_d)
      A_SET, A_STB, A_HLD: begin
        bus_oe_d  = 1'b1;
        bus_out_d = cyc_addr_d;
      end
      D_SET, D_STB, D_HLD: begin
        if (cyc_wr_d) begin
          bus_oe_d  = 1'b1;
          bus_out_d = cyc_wdata_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_wr_q    <= 1'b0;
      cyc_addr_q  <= '0;
      cyc_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ad_q        <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wrs_q       <= 1'b1;
      bus_oe_q    <= 1'b0;
      bus_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_wr_q    <= cyc_wr_d;
      cyc_addr_q  <= cyc_addr_d;
      cyc_wdata_q <= cyc_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ad_q        <= ad_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wrs_q       <= wrs_d;
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
    end
  end

  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.rdata = rdata_q;
  assign AD         = ad_q;
  assign CS         = cs_q;
  assign RD         = rd_q;
  assign WR         = wrs_q;
  assign bus_oe     = bus_oe_q;
  assign bus_out    = bus_out_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench: default-timing and minimum-timing instances checked every cycle against
// a phase-timeline model, plus directed scenarios with literal expectations.
module tb_rtc_bus_cycle;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] bus_in = 8'h00;

  rtc_bus_cycle_if hif0 ();
  rtc_bus_cycle_if hif1 ();
  assign hif0.req = req;   assign hif1.req = req;
  assign hif0.wr = wr;     assign hif1.wr = wr;
  assign hif0.addr = addr; assign hif1.addr = addr;
  assign hif0.wdata = wdata; assign hif1.wdata = wdata;

  logic ad [2], cs [2], rd [2], wrs [2], oe [2], d_busy [2], d_done [2];
  logic [7:0] bo [2], d_rdata [2];
  assign d_busy[0] = hif0.busy;   assign d_busy[1] = hif1.busy;
  assign d_done[0] = hif0.done;   assign d_done[1] = hif1.done;
  assign d_rdata[0] = hif0.rdata; assign d_rdata[1] = hif1.rdata;

  rtc_bus_cycle u_def (
    .clk(clk), .rst(rst), .host(hif0),
    .AD(ad[0]), .CS(cs[0]), .RD(rd[0]), .WR(wrs[0]),
    .bus_out(bo[0]), .bus_oe(oe[0]), .bus_in(bus_in)
  );

  rtc_bus_cycle #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(1), .T_REC(1)) u_fast (
    .clk(clk), .rst(rst), .host(hif1),
    .AD(ad[1]), .CS(cs[1]), .RD(rd[1]), .WR(wrs[1]),
    .bus_out(bo[1]), .bus_oe(oe[1]), .bus_in(bus_in)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d got=%0h want=%0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Phase order: A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, REC.
  function automatic int dur(input int g, input int p);
    int v;
    case (p)
      0, 3:    v = (g == 0) ? 2 : 0;
      1, 4:    v = (g == 0) ? 10 : 1;
      2, 5:    v = (g == 0) ? 2 : 1;
      default: v = (g == 0) ? 4 : 1;
    endcase
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int start_of(input int g, input int p);
    int s = 0;
    for (int q = 0; q < p; q++) s += dur(g, q);
    return s;
  endfunction

  function automatic int phase(input int g, input int k);
    for (int p = 0; p < 7; p++) if (k < start_of(g, p + 1)) return p;
    return 7;
  endfunction

  bit         m_act [2] = '{0, 0};
  int         m_k [2] = '{0, 0};
  bit         m_done [2] = '{0, 0};
  bit         m_wr [2] = '{0, 0};
  logic [7:0] m_addr [2] = '{8'h00, 8'h00};
  logic [7:0] m_wdata [2] = '{8'h00, 8'h00};
  logic [7:0] m_rdata [2] = '{8'h00, 8'h00};

  // Model: k counts edges since acceptance; read data lands on the edge that ends D_STB.
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_act[g] = 1'b0; m_k[g] = 0; m_done[g] = 1'b0; m_rdata[g] = 8'h00;
      end else if (m_act[g]) begin
        m_k[g]++;
        if (!m_wr[g] && (m_k[g] == start_of(g, 5))) m_rdata[g] = bus_in;
        if (m_k[g] == start_of(g, 7)) begin
          m_act[g] = 1'b0;
          m_done[g] = 1'b1;
        end
      end else begin
        m_done[g] = 1'b0;
        if (req) begin
          m_act[g] = 1'b1; m_k[g] = 0;
          m_wr[g] = wr; m_addr[g] = addr; m_wdata[g] = wdata;
        end
      end
    end
  end

  task automatic cmp(input int g);
    logic [6:0] act_v, exp_v;
    int p;
    act_v = {d_busy[g], d_done[g], ad[g], cs[g], rd[g], wrs[g], oe[g]};
    if (m_act[g]) begin
      p = phase(g, m_k[g]);
      exp_v = {1'b1, m_done[g], (p != 1), (p == 6), !(p == 4 && !m_wr[g]),
               !(p == 4 && m_wr[g]), ((p <= 2) || (p <= 5 && m_wr[g]))};
      if (exp_v[0]) check("bus_out", g, bo[g], (p <= 2) ? m_addr[g] : m_wdata[g]);
    end else begin
      exp_v = {1'b0, m_done[g], 5'b11110};
    end
    check("ctl{busy,done,AD,CS,RD,WR,oe}", g, act_v, exp_v);
    check("rdata", g, d_rdata[g], m_rdata[g]);
  endtask

  int c_ad, c_wr, c_rd, c_rec, c_oe0, c_done0, c_bo10;
  int first_done [2];
  int tcount = 0;
  int t0 = 0;

  task automatic clr();
    c_ad = 0; c_wr = 0; c_rd = 0; c_rec = 0; c_oe0 = 0; c_done0 = 0; c_bo10 = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    tcount++;
    cmp(0);
    cmp(1);
    if (!ad[0]) c_ad++;
    if (!wrs[0]) c_wr++;
    if (!rd[0]) c_rd++;
    if (d_busy[0] && cs[0]) c_rec++;
    if (d_busy[0] && !oe[0]) c_oe0++;
    if (d_done[0]) c_done0++;
    if (oe[0] && (bo[0] == 8'h10)) c_bo10++;
    for (int g = 0; g < 2; g++) if (d_done[g] && first_done[g] < 0) first_done[g] = tcount;
  endtask

  task automatic start(input logic w, input logic [7:0] a, input logic [7:0] d);
    wr = w; addr = a; wdata = d; req = 1'b1;
    first_done = '{-1, -1};
    tick();
    t0 = tcount;
    req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && first_done[0] < 0; i++) tick();
  endtask

  function automatic int lat(input int g);
    return (first_done[g] < 0) ? -1 : first_done[g] - t0 + 1;
  endfunction

  initial begin
    clr();
    first_done = '{-1, -1};
    #1 rst = 1'b1;
    #1;
    check("reset_ctl", 0, {d_busy[0], d_done[0], ad[0], cs[0], rd[0], wrs[0], oe[0]}, 7'b0011110);
    check("reset_bus_out", 0, bo[0], 8'h00);
    check("reset_rdata", 0, d_rdata[0], 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Write at defaults.
    clr();
    start(1'b1, 8'h21, 8'h45);
    wait_done();
    check("wr_latency", 0, lat(0), 33);
    check("fast_latency", 1, lat(1), 8);
    check("wr_ad_low", 0, c_ad, 10);
    check("wr_wr_low", 0, c_wr, 10);
    check("wr_rd_low", 0, c_rd, 0);
    check("wr_rec_cs_high", 0, c_rec, 4);
    repeat (3) tick();

    // Read at defaults.
    bus_in = 8'h37;
    clr();
    start(1'b0, 8'h22, 8'h00);
    wait_done();
    check("rd_latency", 0, lat(0), 33);
    check("rd_rd_low", 0, c_rd, 10);
    check("rd_wr_low", 0, c_wr, 0);
    check("rd_oe_low", 0, c_oe0, 18);
    check("rd_rdata", 0, d_rdata[0], 8'h37);
    repeat (3) tick();

    // Request while busy is dropped.
    clr();
    start(1'b1, 8'h30, 8'h55);
    repeat (4) tick();
    addr = 8'h10; req = 1'b1;
    tick();
    req = 1'b0;
    wait_done();
    check("busy_latency", 0, lat(0), 33);
    repeat (40) tick();
    check("busy_done_count", 0, c_done0, 1);
    check("busy_no_0x10", 0, c_bo10, 0);

    // Back-to-back: next request sampled on the done edge.
    clr();
    start(1'b1, 8'h21, 8'h45);
    wait_done();
    check("b2b_first_latency", 0, lat(0), 33);
    bus_in = 8'h5A;
    start(1'b0, 8'h23, 8'h00);
    check("b2b_busy_immediate", 0, d_busy[0], 1'b1);
    wait_done();
    check("b2b_second_latency", 0, lat(0), 33);
    check("b2b_rdata", 0, d_rdata[0], 8'h5A);

    // Reset in the middle of a read strobe.
    bus_in = 8'h66;
    start(1'b0, 8'h24, 8'h00);
    for (int i = 0; i < 100 && rd[0] !== 1'b0; i++) tick();
    check("mid_rd_low_seen", 0, rd[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ctl", 0, {ad[0], cs[0], rd[0], wrs[0], oe[0], d_busy[0], d_done[0]}, 7'b1111000);
    check("mid_rst_rdata", 0, d_rdata[0], 8'h00);
    tick();
    rst = 1'b0;
    clr();
    repeat (50) tick();
    check("mid_rst_no_done", 0, c_done0, 0);
    check("mid_rst_rdata_after", 0, d_rdata[0], 8'h00);
    clr();
    start(1'b1, 8'h21, 8'h45);
    wait_done();
    check("post_rst_latency", 0, lat(0), 33);

    // Random traffic checked by the model on both instances.
    for (int n = 0; n < 3000; n++) begin
      req = ($urandom_range(0, 5) == 0);
      wr = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      wdata = 8'($urandom);
      bus_in = 8'($urandom);
      tick();
    end
    req = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_cycle.md
RTC_BUS_CYCLE -- requirements
Module: rtc_bus_cycle

Interface
REQ-001 The block SHALL have parameter T_SETUP, default 2, giving the clock cycles of bus setup before each strobe.
REQ-002 The block SHALL have parameter T_PULSE, default 10, giving the clock cycles each strobe is held low.
REQ-003 The block SHALL have parameter T_HOLD, default 2, giving the clock cycles the bus is held after each strobe.
REQ-004 The block SHALL have parameter T_REC, default 4, giving the clock cycles of CS-high recovery before done.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port req, input, 1 bit: start one bus cycle, sampled on a rising edge.
REQ-008 The block SHALL have port wr, input, 1 bit: cycle type, 1 = write and 0 = read, sampled with req.
REQ-009 The block SHALL have port addr, input, 8 bits: RTC register address, sampled with req.
REQ-010 The block SHALL have port wdata, input, 8 bits: write data, sampled with req.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a cycle is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a cycle.
REQ-013 The block SHALL have port rdata, output, 8 bits: data captured by the last read cycle.
REQ-014 The block SHALL have ports AD, CS, RD and WR, outputs, 1 bit each: RTC strobes, all active-low.
REQ-015 The block SHALL have port bus_out, output, 8 bits: value driven onto the multiplexed AD bus.
REQ-016 The block SHALL have port bus_oe, output, 1 bit: bus output enable; the top-level tristate drives the bus when it is 1.
REQ-017 The block SHALL have port bus_in, input, 8 bits: value read from the multiplexed AD bus.

Function
REQ-018 All outputs SHALL be driven from registers, so the strobes are glitch-free.
REQ-019 The FSM SHALL have the states IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD and REC, with a dwell of T_SETUP, T_PULSE, T_HOLD, T_SETUP, T_PULSE, T_HOLD and T_REC cycles in the non-IDLE states respectively.
REQ-020 Dwell SHALL be timed by one 8-bit down-counter that is reloaded on each state entry; a parameter value of 0 SHALL behave as 1.
REQ-021 In IDLE, with req=1, the block SHALL latch addr, wdata and wr and enter A_SET on the same edge.
REQ-022 In A_SET the block SHALL drive CS=0, AD=1, bus_oe=1 and bus_out=latched addr.
REQ-023 In A_STB the block SHALL drive AD=0, with CS, bus_oe and the address unchanged.
REQ-024 In A_HLD the block SHALL drive AD=1, with the address still driven.
REQ-025 In D_SET a write SHALL drive bus_out=latched wdata with bus_oe=1, and a read SHALL drive bus_oe=0.
REQ-026 In D_STB a write SHALL drive WR=0 and a read SHALL drive RD=0.
REQ-027 For a read, rdata SHALL capture bus_in on the final D_STB clock edge, i.e. the same edge that raises RD.
REQ-028 In D_HLD RD and WR SHALL be 1 and CS SHALL be 0; write data SHALL still be driven.
REQ-029 In REC the block SHALL drive CS=1 and bus_oe=0.
REQ-030 On leaving REC the block SHALL return to IDLE and pulse done=1 for exactly one cycle.
REQ-031 RD and WR SHALL never both be 0, and AD=0 SHALL never overlap RD=0 or WR=0.
REQ-032 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-033 Latency SHALL be: done is high N = 2*(T_SETUP+T_PULSE+T_HOLD)+T_REC+1 edges after the edge that samples req (N = 33 at defaults).
REQ-034 A req that arrives while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-035 A req sampled on the edge where done is high SHALL be accepted, so back-to-back cycles are legal.
REQ-036 rdata SHALL hold its value through write cycles and until the next read capture.

Reset
REQ-037 On rst=1, asynchronously, the block SHALL force state=IDLE, AD=CS=RD=WR=1, bus_oe=0, bus_out=0x00, rdata=0x00, busy=0 and done=0.
REQ-038 A reset asserted mid-cycle SHALL abort the cycle with no done pulse and no rdata update.
REQ-039 After reset is released, the first req SHALL start a fresh cycle with full timing.

Verification
REQ-040 Scenario, write at defaults: req with wr=1, addr=0x21, wdata=0x45 -> bus_out=0x21 with AD low for 10 cycles, then bus_out=0x45 with WR low for 10 cycles, CS high for 4 cycles, and done 33 edges after the req edge.
REQ-041 Scenario, read: req with wr=0, addr=0x22 and bus_in=0x37 during D_STB -> RD low for 10 cycles, bus_oe=0 from D_SET onward, and rdata=0x37 at done.
REQ-042 Scenario, busy rejection: a second req with addr=0x10 issued 5 cycles after the first -> ignored, only one done pulse, and bus_out never 0x10.
REQ-043 Scenario, back-to-back: a read of 0x23 issued on the done edge of a write of 0x21 -> second cycle starts immediately and a second done follows 33 edges later.
REQ-044 Scenario, reset mid-op: rst during D_STB of a read -> all strobes high and bus_oe=0 before the next edge, no done pulse, and rdata=0x00.
REQ-045 Scenario, parameters T_SETUP=0, T_PULSE=1, T_HOLD=1, T_REC=1 -> each phase lasts 1 cycle and done fires 8 edges after req.
